com_tpram_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that initiates accesses to an external two-port RAM through a com_tpram2ck_shell-style port set (write: strobe/addr/data; read: enable/addr, data returned one cycle later). It converts the raw RAM port into a valid/ready stream FIFO with full throughput and a registered 2-entry output buffer that hides the RAM read latency. It sits between a producer stream and a consumer stream. The RAM instance lives outside the block, with both RAM clocks tied to clk.

---
 rtl/com_tpram_fifo_ctrl.sv | 107 ++++++++++
 tb/tb_com_tpram_fifo_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/com_tpram_fifo_ctrl.sv
// Valid/ready stream FIFO built on an external two-port RAM (1-cycle read latency).
// A registered 2-entry output buffer hides the read latency and sustains 1 word/cycle.
module com_tpram_fifo_ctrl #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int STRB_W   = 1,
    parameter int AFULL_TH = DEPTH,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int LVL_W   = $clog2(DEPTH + 3)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LVL_W-1:0]  level,
    output logic              almost_full,
    output logic [STRB_W-1:0] mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [LVL_W-1:0]  ram_cnt;
    logic              inflight;
    logic [DATA_W-1:0] ob [2];
    logic [1:0]        ob_cnt;

    logic              push;
    logic              pop;
    logic              rd_go;
    logic [2:0]        ob_pending;
    logic [1:0]        ob_base;
    logic [DATA_W-1:0] ob_nxt [2];

    assign in_ready  = rst_n && (ram_cnt < LVL_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign out_valid = (ob_cnt != 2'd0);
    assign out_data  = ob[0];
    assign pop       = out_valid && out_ready;

    // Buffer slots still needed after this cycle's pop; a read is issued only if one is free.
    assign ob_pending = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_go      = rst_n && (ram_cnt != '0) && (ob_pending < 3'd2);

    assign mem_wr_en   = {STRB_W{push}};
    assign mem_wr_addr = wptr;
    assign mem_wr_data = in_data;
    assign mem_rd_en   = rd_go;
    assign mem_rd_addr = rptr;

    assign level       = ram_cnt + LVL_W'(ob_cnt) + LVL_W'(inflight);
    assign almost_full = (level >= LVL_W'(AFULL_TH));

    // Shift on pop, then land the returning RAM word in the first free slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ob_nxt[0] = ob[0];
        ob_nxt[1] = ob[1];
        ob_base   = ob_cnt;
        if (pop) begin
            ob_nxt[0] = ob[1];
            ob_base   = ob_cnt - 2'd1;
        end
        if (inflight) begin
            if (ob_base == 2'd0) ob_nxt[0] = mem_rd_data;
            else                 ob_nxt[1] = mem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the output buffer is reset so out_data reads 0; the RAM itself is never cleared.
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            ob_cnt   <= 2'd0;
            ob[0]    <= '0;
            ob[1]    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same clock edge.
            if (push) wptr <= (wptr == ADDR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (rd_go) rptr <= (rptr == ADDR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            ram_cnt  <= ram_cnt + LVL_W'(push) - LVL_W'(rd_go);
            inflight <= rd_go;
            ob_cnt   <= ob_cnt - 2'(pop) + 2'(inflight);
            ob[0]    <= ob_nxt[0];
            ob[1]    <= ob_nxt[1];
        end
    end

`ifdef COM_REPORT_ON
    a_in_valid_known: assert property (@(posedge clk) rst_n |-> !$isunknown(in_valid));
    a_ram_cnt_max:    assert property (@(posedge clk) disable iff (!rst_n) ram_cnt <= LVL_W'(DEPTH));
    a_ob_occupancy:   assert property (@(posedge clk) disable iff (!rst_n)
                                       ({1'b0, ob_cnt} + {2'b00, inflight}) <= 3'd2);
`endif

endmodule

// File: tb/tb_com_tpram_fifo_ctrl.sv
// Directed bench for com_tpram_fifo_ctrl (DEPTH=4, DATA_W=32, AFULL_TH=5) with a behavioural RAM.
module tb_com_tpram_fifo_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 3);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [LVL_W-1:0]  level;
    logic              almost_full;
    logic [0:0]        mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    com_tpram_fifo_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .STRB_W(1), .AFULL_TH(5)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .almost_full(almost_full),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    // Two-port RAM model, both ports on clk, registered read data.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_wr_en[0]) ram[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en)    mem_rd_data <= ram[mem_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, recv, cyc, first, last, first_block;
        logic hold;
        logic [DATA_W-1:0] held;

        // Reset gating and post-reset state
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b0;
        @(negedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_rd_en", mem_rd_en, 0);
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_level", level, 0);
        check("post_rst_afull", almost_full, 0);
        check("post_rst_out_data", out_data, 0);
        check("post_rst_in_ready", in_ready, 1);

        // Single word latency
        @(negedge clk); in_valid = 1'b1; in_data = 32'hA5A5A5A5; #1;
        check("t1_wr_en", mem_wr_en, 1);
        check("t1_wr_addr", mem_wr_addr, 0);
        check("t1_wr_data", mem_wr_data, 32'hA5A5A5A5);
        @(negedge clk); in_valid = 1'b0; #1;
        check("t1_rd_en", mem_rd_en, 1);
        check("t1_rd_addr", mem_rd_addr, 0);
        check("t1_level_a", level, 1);
        @(negedge clk); #1;
        check("t1_out_valid_early", out_valid, 0);
        check("t1_level_b", level, 1);
        @(negedge clk); #1;
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data", out_data, 32'hA5A5A5A5);
        check("t1_level_c", level, 1);
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0; #1;
        check("t1_level_pop", level, 0);
        check("t1_out_valid_pop", out_valid, 0);

        // Fill with stalled consumer, then drain
        apply_reset();
        sent = 0; first_block = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); in_valid = 1'b1; in_data = sent; #1;
            if (in_ready) sent++;
            else if (first_block < 0) first_block = c;
        end
        check("t2_accepted", sent, 6);
        check("t2_first_block", first_block, 6);
        check("t2_level", level, 6);
        check("t2_in_ready", in_ready, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
            check("t2_drain_valid", out_valid, 1);
            check("t2_drain_data", out_data, k);
        end
        @(negedge clk); out_ready = 1'b0; #1;
        check("t2_empty_valid", out_valid, 0);
        check("t2_empty_level", level, 0);

        // Streaming with address wrap
        apply_reset();
        sent = 0; recv = 0; cyc = 0; first = -1; last = -1;
        while (recv < 20 && cyc < 200) begin
            @(negedge clk);
            in_valid = (sent < 20); in_data = 32'h1000 + sent; out_ready = 1'b1; #1;
            if (in_valid && in_ready) begin
                check("t3_wr_addr", mem_wr_addr, sent % DEPTH);
                sent++;
            end
            if (out_valid) begin
                check("t3_data", out_data, 32'h1000 + recv);
                if (recv == 0) first = cyc;
                last = cyc;
                recv++;
            end
            cyc++;
        end
        check("t3_count", recv, 20);
        check("t3_first_latency", first, 3);
        check("t3_no_bubbles", last - first, 19);

        // Random backpressure with scoreboard and hold-stability checks
        apply_reset();
        sent = 0; recv = 0; cyc = 0; hold = 1'b0; held = '0;
        while (recv < 200 && cyc < 5000) begin
            @(negedge clk);
            if (hold) begin
                check("t4_hold_valid", out_valid, 1);
                check("t4_hold_data", out_data, held);
            end
            in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            in_data   = 32'h5000 + sent;
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check("t4_data", out_data, 32'h5000 + recv);
                recv++;
            end
            hold = out_valid && !out_ready;
            held = out_data;
            cyc++;
        end
        check("t4_count", recv, 200);

        // Reset in the cycle a read is issued
        apply_reset();
        @(negedge clk); in_valid = 1'b1; in_data = 32'hDEADBEEF;
        @(negedge clk); in_valid = 1'b0; #1;
        check("t5_rd_en", mem_rd_en, 1);
        rst_n = 1'b0; #1;
        check("t5_rd_en_gated", mem_rd_en, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("t5_level", level, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("t5_stays_empty", out_valid, 0);
            check("t5_out_data", out_data, 0);
        end

        // Reset while the read data is returning
        @(negedge clk); in_valid = 1'b1; in_data = 32'hCAFEF00D;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        check("t5b_returning", mem_rd_data, 32'hCAFEF00D);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("t5b_out_valid", out_valid, 0);
            check("t5b_out_data", out_data, 0);
            check("t5b_level", level, 0);
        end

        // almost_full threshold at level 5
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); in_valid = 1'b1; in_data = k;
            @(posedge clk); #1;
            check("t6_level", level, k);
            check("t6_afull", almost_full, (k >= 5) ? 1 : 0);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("t6_level_pop", level, 4);
        check("t6_afull_pop", almost_full, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
